// File: rtl/bus_b_transfer_scheduler_pkg.sv
// bus_b_transfer_scheduler_pkg: shared bus-B source codes, destination bits, FSM states and command format
package bus_b_transfer_scheduler_pkg;
  localparam logic [3:0] SRC_RAM   = 4'd0;
  localparam logic [3:0] SRC_PC    = 4'd1;
  localparam logic [3:0] SRC_R1    = 4'd2;
  localparam logic [3:0] SRC_R2    = 4'd3;
  localparam logic [3:0] SRC_TR    = 4'd4;
  localparam logic [3:0] SRC_R     = 4'd5;
  localparam logic [3:0] SRC_AC    = 4'd6;
  localparam logic [3:0] SRC_INSTR = 4'd7;
  localparam logic [3:0] SRC_AR    = 4'd8;
  localparam int DST_AR = 0;
  localparam int DST_PC = 1;
  localparam int DST_R1 = 2;
  localparam int DST_R2 = 3;
  localparam int DST_TR = 4;
  localparam int DST_R  = 5;
  localparam int DST_AC = 6;
  localparam int DST_IR = 7;
  typedef enum logic [1:0] {IDLE, MEM_WAIT, DRIVE} state_t;
  typedef struct packed {
    logic [3:0] src;
    logic [7:0] dst;
  } cmd_t;
  function automatic logic src_is_reg(input logic [3:0] s);
    return (s >= SRC_PC && s <= SRC_AC) || s == SRC_AR;
  endfunction
endpackage

// File: rtl/bus_b_transfer_scheduler_cmd_fifo.sv
// bus_b_cmd_fifo: synchronous command FIFO with wrap-bit pointers and next-state flags
module bus_b_cmd_fifo
  import bus_b_transfer_scheduler_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  cmd_t wdata,
  output cmd_t rdata,
  output logic full,
  output logic empty,
  output logic full_next,
  output logic empty_next
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wp, rp, wp_n, rp_n;
  logic do_push, do_pop;
  cmd_t mem [DEPTH];
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign empty = wp == rp;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign wp_n = wp + (AW+1)'(do_push);
  assign rp_n = rp + (AW+1)'(do_pop);
  assign full_next = (wp_n[AW] != rp_n[AW]) && (wp_n[AW-1:0] == rp_n[AW-1:0]);
  assign empty_next = wp_n == rp_n;
  assign rdata = mem[rp[AW-1:0]];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      wp <= wp_n;
      rp <= rp_n;
    end
  always_ff @(posedge clk)
    if (do_push) mem[wp[AW-1:0]] <= wdata;
endmodule

// File: rtl/bus_b_transfer_scheduler.sv
// bus_b_transfer_scheduler: sequences queued bus-B transfers, waiting out memory latency before pulsing write enables
module bus_b_transfer_scheduler
  import bus_b_transfer_scheduler_pkg::*;
#(
  parameter int FIFO_DEPTH   = 4,
  parameter int RAM_LATENCY  = 2,
  parameter int IMEM_LATENCY = 1
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic       CMD_VALID,
  output logic       CMD_READY,
  input  logic [3:0] CMD_SRC,
  input  logic [7:0] CMD_DST,
  output logic [3:0] SELECT,
  output logic [7:0] WRITE_EN,
  output logic       RAM_READ,
  output logic       INSTR_READ,
  output logic       BUSY,
  output logic       ERR
);
  localparam int MAXLAT = RAM_LATENCY > IMEM_LATENCY ? RAM_LATENCY : IMEM_LATENCY;
  localparam int CW = $clog2(MAXLAT + 1);
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [7:0] dst_q, dst_n, we_n;
  logic [3:0] sel_n;
  logic rr_n, ir_n, err_n, busy_n, pop, push;
  logic full, empty, full_next, empty_next;
  cmd_t head;
  assign push = CMD_VALID && CMD_READY;
  bus_b_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(CLOCK),
    .rst(RESET),
    .push(push),
    .pop(pop),
    .wdata('{src: CMD_SRC, dst: CMD_DST}),
    .rdata(head),
    .full(full),
    .empty(empty),
    .full_next(full_next),
    .empty_next(empty_next)
  );
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    dst_n = dst_q;
    sel_n = SELECT;
    we_n = '0;
    rr_n = 1'b0;
    ir_n = 1'b0;
    err_n = 1'b0;
    pop = 1'b0;
    case (state)
      MEM_WAIT:
        if (cnt == CW'(1)) begin
          state_n = DRIVE;
          we_n = dst_q;
        end else begin
          cnt_n = cnt - CW'(1);
          rr_n = RAM_READ;
          ir_n = INSTR_READ;
        end
      IDLE, DRIVE: begin
        state_n = IDLE;
        // DRIVE pops straight into the next command so register moves stream at one per cycle
        if (!empty) begin
          pop = 1'b1;
          dst_n = head.dst;
          if (head.src == SRC_RAM || head.src == SRC_INSTR) begin
            state_n = MEM_WAIT;
            sel_n = head.src;
            rr_n = head.src == SRC_RAM;
            ir_n = head.src == SRC_INSTR;
            cnt_n = head.src == SRC_RAM ? CW'(RAM_LATENCY) : CW'(IMEM_LATENCY);
          end else if (src_is_reg(head.src)) begin
            state_n = DRIVE;
            sel_n = head.src;
            we_n = head.dst;
          end else err_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    busy_n = state_n != IDLE || !empty_next;
  end
  always_ff @(posedge CLOCK or posedge RESET)
    if (RESET) begin
      state <= IDLE;
      cnt <= '0;
      dst_q <= '0;
      SELECT <= '0;
      WRITE_EN <= '0;
      RAM_READ <= 1'b0;
      INSTR_READ <= 1'b0;
      ERR <= 1'b0;
      BUSY <= 1'b0;
      CMD_READY <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      dst_q <= dst_n;
      SELECT <= sel_n;
      WRITE_EN <= we_n;
      RAM_READ <= rr_n;
      INSTR_READ <= ir_n;
      ERR <= err_n;
      BUSY <= busy_n;
      CMD_READY <= !full_next;
    end
endmodule

// File: doc/bus_b_transfer_scheduler.md
Name: bus_b_transfer_scheduler

Overview:
- Sequences all transfers onto the processor's 16-bit bus B.
- Accepts transfer commands (source code plus destination write mask) from the control unit through a small command FIFO.
- Drives the bus-B mux SELECT and waits for RAM or instruction-memory latency where needed. It then pulses the destination register write enables for exactly one cycle.
- Sits between the control unit and the bus-B mux/register file.

Parameters:
- FIFO_DEPTH, 4, number of queued commands (power of 2, >=2)
- RAM_LATENCY, 2, cycles from RAM_READ assertion to DATA_FROM_RAM valid (>=1)
- IMEM_LATENCY, 1, cycles from INSTR_READ assertion to INSTRUCTIONS valid (>=1)

Ports:
- CLOCK  input  1  system clock, rising edge
- RESET  input  1  asynchronous, active-high reset
- CMD_VALID  input  1  command offered
- CMD_READY  output  1  FIFO can accept a command
- CMD_SRC  input  4  bus-B source code (0 RAM, 1 PC, 2 R1, 3 R2, 4 TR, 5 R, 6 AC, 7 INSTRUCTIONS, 8 AR)
- CMD_DST  input  8  destination write mask (bit0 AR, 1 PC, 2 R1, 3 R2, 4 TR, 5 R, 6 AC, 7 IR)
- SELECT  output  4  bus-B mux select
- WRITE_EN  output  8  one-cycle destination write enables
- RAM_READ  output  1  data-RAM read strobe
- INSTR_READ  output  1  instruction-memory read strobe
- BUSY  output  1  high when the FSM is not IDLE or the FIFO is non-empty
- ERR  output  1  one-cycle pulse when an illegal source is dropped

Behaviour:
- All outputs are registered. During reset: SELECT=0, WRITE_EN=0, RAM_READ=0, INSTR_READ=0, ERR=0, BUSY=0, CMD_READY=0. CMD_READY rises on the first edge after reset deasserts.
- Handshake:
  - A push occurs at an edge where CMD_VALID && CMD_READY.
  - CMD_READY = !full. There is no bypass when full, even if a pop happens in the same cycle.
  - Simultaneous push and pop are legal when not full.
- The FSM has three states: IDLE, MEM_WAIT, DRIVE.
- IDLE, FIFO non-empty: pop the head at the next edge. The FSM reads only entries already in the FIFO, so a command pushed at edge E0 is popped at E1 at the earliest.
  - src 1-6 or 8 -> DRIVE.
  - src 0 -> MEM_WAIT, counter = RAM_LATENCY, RAM_READ=1.
  - src 7 -> MEM_WAIT, counter = IMEM_LATENCY, INSTR_READ=1.
  - src 9-15 -> stay IDLE, ERR=1 for one cycle, no WRITE_EN, no strobes. The command is discarded.
- SELECT is loaded with the popped src on entry to MEM_WAIT or DRIVE. It holds its last legal value in IDLE and is never driven to 9-15.
- MEM_WAIT:
  - The read strobe stays high, and the counter decrements each cycle.
  - When the counter reaches 1, the next edge enters DRIVE and the strobe drops.
  - Total MEM_WAIT cycles = latency parameter.
- DRIVE:
  - WRITE_EN = latched dst for exactly this cycle.
  - At the next edge, if the FIFO is non-empty, pop directly using the IDLE rules. Back-to-back register-source transfers therefore achieve 1 per cycle. Otherwise go to IDLE.
- Latency from push: a register source gives WRITE_EN in the cycle after E1; a RAM source gives WRITE_EN after E1+RAM_LATENCY.
- dst=0 is legal: the command is sequenced normally with WRITE_EN=0.
- Reset mid-operation flushes the FIFO, forces IDLE and clears all outputs immediately. An in-flight transfer is lost without a write.
- FIFO pointers carry one extra wrap bit. full/empty are derived from the pointers, and the pointers wrap modulo FIFO_DEPTH.

Decomposition:
- A shared processor package holds:
  - source codes SRC_RAM..SRC_AR (4-bit)
  - destination bit indices DST_AR..DST_IR
  - the state encoding (IDLE/MEM_WAIT/DRIVE)
  - the command struct {src[3:0], dst[7:0]}
- One sub-module: bus_b_cmd_fifo, a 12-bit-wide synchronous FIFO with async reset and full/empty flags.
- The FSM, latency counter and output registers live in the top module.

Test Plan:
- Reset, then push {src=2, dst=8'h40} -> SELECT=2 with WRITE_EN=8'h40 for one cycle, in the cycle after the pop edge. BUSY returns to 0 afterwards.
- Push src=0, dst=8'h01 with RAM_LATENCY=2 -> RAM_READ high for 2 cycles with SELECT=0, then WRITE_EN=8'h01 for one cycle.
- Push src=7, dst=8'h80 -> INSTR_READ high for 1 cycle, then WRITE_EN=8'h80. SELECT=7 throughout.
- Push 5 commands with CMD_VALID held high and the FSM stalled on a RAM read -> CMD_READY=0 after 4 commands are queued. The 5th is accepted only after the first pop. All 5 execute in order; register sources complete one per cycle.
- Push src=4'hC, then src=1 -> ERR pulses once, no WRITE_EN for the bad command, SELECT never shows C. The src=1 transfer completes normally.
- Assert RESET during MEM_WAIT with 2 commands queued -> all outputs 0 immediately, no WRITE_EN. BUSY=0 and the FIFO is empty after release.
